cache_ctrl: RTL
===============

Name: cache_ctrl

Overview:
Request sequencer between the bf8b core's data port and the LRU cache.
- Read hit: data is served from the cache.
- Read miss: fetches from backing memory over a req/ack handshake, then fills the cache.
- Write: write-through to both cache and memory.
- Also keeps hit/miss statistics and a memory-timeout error.

Parameters:
ADDR_WIDTH, 8, address width on all three sides
DATA_WIDTH, 8, data width on all three sides
TIMEOUT, 255, max cycles waiting for mem_ack before abort; 0 disables timeout
STAT_WIDTH, 16, width of saturating hit/miss counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cpu_req  in  1  request; sampled only in IDLE
cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
cpu_addr  in  ADDR_WIDTH  request address; captured on accept
cpu_wdata  in  DATA_WIDTH  write data; captured on accept
cpu_rdata  out  DATA_WIDTH  read result; registered, held until next accept
cpu_done  out  1  one-cycle completion pulse
cpu_err  out  1  qualifies cpu_done: memory timeout on this request
cache_addr  out  ADDR_WIDTH  cache address (captured request address)
cache_we  out  1  cache write strobe
cache_wdata  out  DATA_WIDTH  cache write data; cache data bus is driven externally from this when cache_we=1
cache_rdata  in  DATA_WIDTH  cache read data; valid the cycle after lookup
cache_hit  in  1  cache hit; valid the cycle after lookup
mem_req  out  1  memory request, held until ack
mem_we  out  1  memory write
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data; valid with mem_ack
mem_ack  in  1  one-cycle memory acknowledge
stat_clr  in  1  synchronous clear of both counters
hit_cnt  out  STAT_WIDTH  read hits
miss_cnt  out  STAT_WIDTH  read misses

Behaviour:
Reset:
- State IDLE.
- All outputs 0, including cpu_rdata and both counters.
- rst mid-transaction aborts immediately; mem_req and cache_we drop asynchronously.

States: IDLE, LOOKUP, CHECK, MEM_RD, FILL, WR_CACHE, WR_MEM, SETTLE, DONE.

IDLE:
- On the edge with cpu_req=1, capture addr/we/wdata.
- Go to LOOKUP (read) or WR_CACHE (write).

LOOKUP: cache_addr driven, cache_we=0, one cycle, then CHECK.

CHECK:
- Sample cache_hit and cache_rdata.
- Hit: cpu_rdata <= cache_rdata, hit_cnt++, go to SETTLE.
- Miss: miss_cnt++, go to MEM_RD.

MEM_RD:
- mem_req=1, mem_we=0, mem_addr stable.
- On mem_ack: capture mem_rdata into cpu_rdata and cache_wdata, go to FILL.

FILL: cache_we=1 for exactly one cycle, then SETTLE.

WR_CACHE:
- cache_we=1 with cpu_wdata for one cycle.
- mem_req=1, mem_we=1 asserted in the same cycle.
- mem_ack sampled here goes to SETTLE; otherwise go to WR_MEM.

WR_MEM: hold mem_req until mem_ack, then SETTLE.

SETTLE:
- One idle cycle; cache_we=0, cache_addr held.
- Covers the cache's shift/promotion cycle after any hit or write.

DONE:
- cpu_done=1 for one cycle, then IDLE.
- cpu_req still high in the following IDLE cycle is accepted as a new request; minimum one IDLE cycle between requests.

Latency, with acceptance at edge N:
- Read hit: cpu_done high in cycle N+3..N+4.
- Read miss: with mem_ack sampled at edge M, cpu_done high M+2..M+3.
- Write: with ack at edge M ≥ N+1, cpu_done high M+2..M+3.

Memory handshake:
- mem_req/mem_we/mem_addr/mem_wdata stay stable from assertion until the edge where mem_ack=1.
- mem_req is low in the next cycle.
- mem_ack outside MEM_RD/WR_CACHE/WR_MEM is ignored.

Timeout:
- Counter resets on entry to a memory state.
- If TIMEOUT ≠ 0 and TIMEOUT cycles elapse with no ack: drop mem_req, skip FILL, go to SETTLE.
- That request completes with cpu_err=1 alongside cpu_done.
- A timed-out read returns cpu_rdata = all ones.
- Ack on the same edge as expiry counts as success.

Counters:
- Saturate at all ones.
- stat_clr has priority over an increment in the same cycle.
- Writes are not counted.

cpu_err is 0 on every non-aborted cpu_done.

Test Plan:
- After rst, read addr 0xFF (cache powers up all-ones tags/data) -> hit, cpu_rdata=0xFF, cpu_done at N+3, no mem_req, hit_cnt=1.
- Read 0x10, memory acks with 0x5A after 3 cycles -> one mem_req burst (mem_we=0, mem_addr=0x10), one-cycle cache_we with 0x5A, cpu_rdata=0x5A, miss_cnt=1; reread 0x10 -> hit, 0x5A, no mem_req.
- Write 0x20=0xC3 with mem_ack on the first cycle -> cache_we one cycle, mem_we=1 mem_wdata=0xC3, cpu_done 3 cycles after accept; read 0x20 -> hit 0xC3.
- TIMEOUT=4, read miss with mem_ack never asserted -> mem_req drops after 4 cycles, no cache_we, cpu_done with cpu_err=1, cpu_rdata=0xFF.
- Assert rst while in MEM_RD -> mem_req=0 immediately; after release, state IDLE and counters 0.
- STAT_WIDTH=2, four read hits then stat_clr coincident with a fifth hit -> hit_cnt saturates at 3, then reads 0.

Source files
------------

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - request sequencer between the core data port, the LRU cache and backing memory
module cache_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_done,
    output logic                  cpu_err,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic                  cache_we,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    input  logic                  cache_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    input  logic                  stat_clr,
    output logic [STAT_WIDTH-1:0] hit_cnt,
    output logic [STAT_WIDTH-1:0] miss_cnt
);
    typedef enum logic [3:0] {
        IDLE, LOOKUP, CHECK, MEM_RD, FILL, WR_CACHE, WR_MEM, SETTLE, DONE
    } state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state;
    logic [TW-1:0] tcnt;
    logic          err_q;
    logic          wr_hold;
    logic          expired;

    // tcnt counts edges since mem_req rose; an ack on the expiry edge wins
    assign expired = (TIMEOUT != 0) && (tcnt == TLAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            err_q       <= 1'b0;
            wr_hold     <= 1'b0;
            cpu_rdata   <= '0;
            cpu_done    <= 1'b0;
            cpu_err     <= 1'b0;
            cache_addr  <= '0;
            cache_we    <= 1'b0;
            cache_wdata <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        cache_addr <= cpu_addr;
                        mem_addr   <= cpu_addr;
                        err_q      <= 1'b0;
                        tcnt       <= '0;
                        if (cpu_we) begin
                            cache_we    <= 1'b1;
                            cache_wdata <= cpu_wdata;
                            mem_req     <= 1'b1;
                            mem_we      <= 1'b1;
                            mem_wdata   <= cpu_wdata;
                            wr_hold     <= 1'b1;
                            state       <= WR_CACHE;
                        end else begin
                            state <= LOOKUP;
                        end
                    end
                end
                LOOKUP: state <= CHECK;
                CHECK: begin
                    if (cache_hit) begin
                        cpu_rdata <= cache_rdata;
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + STAT_WIDTH'(1);
                        state <= SETTLE;
                    end else begin
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + STAT_WIDTH'(1);
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        tcnt    <= '0;
                        state   <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (mem_ack) begin
                        cpu_rdata   <= mem_rdata;
                        cache_wdata <= mem_rdata;
                        cache_we    <= 1'b1;
                        mem_req     <= 1'b0;
                        state       <= FILL;
                    end else if (expired) begin
                        mem_req   <= 1'b0;
                        cpu_rdata <= '1;
                        err_q     <= 1'b1;
                        state     <= SETTLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                FILL: begin
                    cache_we <= 1'b0;
                    state    <= SETTLE;
                end
                WR_CACHE, WR_MEM: begin
                    cache_we <= 1'b0;
                    if (mem_ack || expired) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        err_q   <= !mem_ack;
                        state   <= SETTLE;
                    end else begin
                        tcnt  <= tcnt + TW'(1);
                        state <= WR_MEM;
                    end
                end
                SETTLE: begin
                    // writes spend two cycles here so completion trails the ack by two edges, like a read fill
                    if (wr_hold) begin
                        wr_hold <= 1'b0;
                    end else begin
                        cpu_done <= 1'b1;
                        cpu_err  <= err_q;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    cpu_done <= 1'b0;
                    cpu_err  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (stat_clr) begin
                hit_cnt  <= '0;
                miss_cnt <= '0;
            end
        end
    end
endmodule
